// File: rtl/apb_bridge_pkg.sv
// Shared types and constants for the AHB-to-APB bridge controller.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
// Contents: 8-state controller enum, slave decode tags for haddr[31:26],
//           default bus widths.
package apb_bridge_pkg;

  localparam int DEFAULT_ADDR_W = 32;
  localparam int DEFAULT_DATA_W = 32;

  // Upper six address bits that select each APB slave.
  localparam logic [5:0] SLV0_BASE = 6'b100000;
  localparam logic [5:0] SLV1_BASE = 6'b100001;
  localparam logic [5:0] SLV2_BASE = 6'b100010;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_WWAIT    = 3'd1,
    ST_READ     = 3'd2,
    ST_WRITE    = 3'd3,
    ST_WRITEP   = 3'd4,
    ST_RENABLE  = 3'd5,
    ST_WENABLE  = 3'd6,
    ST_WENABLEP = 3'd7
  } apb_state_e;

endpackage

// File: rtl/apb_addr_decode.sv
// Address decoder: maps addr[31:26] to a one-hot APB slave select.
// Latency: combinational.
// Backpressure: none; unmatched addresses give an all-zero select.
// Ports: addr (in, ADDR_W) -> sel (out, NSLV one-hot).
module apb_addr_decode
  import apb_bridge_pkg::*;
#(
  parameter int ADDR_W = DEFAULT_ADDR_W,
  parameter int NSLV   = 3
) (
  input  logic [ADDR_W-1:0] addr,
  output logic [NSLV-1:0]   sel
);

  logic [5:0] tag;
  logic [2:0] hit;

  always_comb begin
    tag = addr[31:26];
    hit = 3'b000;
    if (tag == SLV0_BASE) hit = 3'b001;
    if (tag == SLV1_BASE) hit = 3'b010;
    if (tag == SLV2_BASE) hit = 3'b100;
    sel = NSLV'(hit);
  end

endmodule

// File: rtl/apb_controller.sv
// APB master FSM of an AHB-to-APB bridge; sequences SETUP/ENABLE phases with write pipelining.
// Latency: read 3 hclk from acceptance to hrdata; single write 3 hclk (WWAIT, SETUP, ENABLE).
// Backpressure: hr_readyout drops during every SETUP phase; valid is ignored while it is low.
// Ports: hclk/hreset (sync, active-high); AHB side valid/haddr/hwrite/hwdata in,
//        hr_readyout/hrdata out; APB side penable/pwrite/pselx/paddr/pwdata out, prdata in.
// Optional: `define APB_PSLVERR_EN adds pslverr (in) and hresp (out); an error seen in an
//           ENABLE phase raises hresp for one cycle and returns the FSM to ST_IDLE.
module apb_controller
  import apb_bridge_pkg::*;
#(
  parameter int ADDR_W = DEFAULT_ADDR_W,
  parameter int DATA_W = DEFAULT_DATA_W,
  parameter int NSLV   = 3
) (
  input  logic              hclk,
  input  logic              hreset,
  input  logic              valid,
  input  logic [ADDR_W-1:0] haddr,
  input  logic              hwrite,
  input  logic [DATA_W-1:0] hwdata,
  input  logic [DATA_W-1:0] prdata,
`ifdef APB_PSLVERR_EN
  input  logic              pslverr,
`endif
  output logic              penable,
  output logic              pwrite,
  output logic [NSLV-1:0]   pselx,
  output logic [ADDR_W-1:0] paddr,
  output logic [DATA_W-1:0] pwdata,
  output logic              hr_readyout,
`ifdef APB_PSLVERR_EN
  output logic              hresp,
`endif
  output logic [DATA_W-1:0] hrdata
);

  apb_state_e        state_q, state_d;
  logic              penable_q, penable_d;
  logic              pwrite_q, pwrite_d;
  logic [NSLV-1:0]   pselx_q, pselx_d;
  logic [ADDR_W-1:0] paddr_q, paddr_d;
  logic [DATA_W-1:0] pwdata_q, pwdata_d;
  logic              ready_q, ready_d;
  logic [ADDR_W-1:0] addr_a_q, addr_a_d;
  logic [ADDR_W-1:0] addr_b_q, addr_b_d;
  logic              hwrite_reg_q, hwrite_reg_d;
  logic [DATA_W-1:0] wdata_r_q, wdata_r_d;
  logic              wr_acc_q, wr_acc_d;
  logic              acc;
  logic [ADDR_W-1:0] issue_addr;
  logic [NSLV-1:0]   issue_sel;
  logic              err_abort;
`ifdef APB_PSLVERR_EN
  logic              hresp_q, hresp_d;
`endif

  // Only a transfer presented while we are ready counts.
  assign acc = valid & ready_q;

`ifdef APB_PSLVERR_EN
  assign err_abort = pslverr & (state_q inside {ST_RENABLE, ST_WENABLE, ST_WENABLEP});
  assign hresp_d   = err_abort;
  assign hresp     = hresp_q;
`else
  assign err_abort = 1'b0;
`endif

  // Capture registers. addr_b takes addresses accepted while a write is still in
  // flight; it is the source of the next issue out of ST_WENABLEP. Write data
  // arrives one cycle after its address, hence the wr_acc delay.
  always_comb begin
    addr_a_d     = acc ? haddr : addr_a_q;
    hwrite_reg_d = acc ? hwrite : hwrite_reg_q;
    addr_b_d     = (acc && (state_q inside {ST_WWAIT, ST_WENABLEP})) ? haddr : addr_b_q;
    wr_acc_d     = acc & hwrite;
    wdata_r_d    = wr_acc_q ? hwdata : wdata_r_q;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE, ST_RENABLE, ST_WENABLE: begin
        if (acc) state_d = hwrite ? ST_WWAIT : ST_READ;
        else     state_d = ST_IDLE;
      end
      ST_WWAIT:  state_d = acc ? ST_WRITEP : ST_WRITE;
      ST_READ:   state_d = ST_RENABLE;
      ST_WRITE:  state_d = acc ? ST_WENABLEP : ST_WENABLE;
      ST_WRITEP: state_d = ST_WENABLEP;
      ST_WENABLEP: begin
        if (!hwrite_reg_q) state_d = ST_READ;
        else if (acc)      state_d = ST_WRITEP;
        else               state_d = ST_WRITE;
      end
      default:   state_d = ST_IDLE;
    endcase
    if (err_abort) state_d = ST_IDLE;
  end

  // Address for the SETUP phase being entered: a fresh read comes straight off
  // haddr, the pipelined pending transfer off addr_b, a single write off addr_a.
  always_comb begin
    if (state_q == ST_WENABLEP)  issue_addr = addr_b_q;
    else if (state_d == ST_READ) issue_addr = haddr;
    else                         issue_addr = addr_a_q;
  end

  apb_addr_decode #(.ADDR_W(ADDR_W), .NSLV(NSLV)) u_dec (
    .addr (issue_addr),
    .sel  (issue_sel)
  );

  // Outputs are registered from the next state so they line up with it.
  always_comb begin
    pselx_d   = pselx_q;
    paddr_d   = paddr_q;
    pwrite_d  = pwrite_q;
    pwdata_d  = pwdata_q;
    penable_d = 1'b0;
    ready_d   = 1'b1;
    case (state_d)
      ST_READ: begin
        pselx_d  = issue_sel;
        paddr_d  = issue_addr;
        pwrite_d = 1'b0;
        ready_d  = 1'b0;
      end
      ST_WRITE, ST_WRITEP: begin
        pselx_d  = issue_sel;
        paddr_d  = issue_addr;
        pwrite_d = 1'b1;
        pwdata_d = wdata_r_d;
        ready_d  = 1'b0;
      end
      ST_RENABLE, ST_WENABLE, ST_WENABLEP: penable_d = 1'b1;
      default: pselx_d = '0;
    endcase
  end

  always_ff @(posedge hclk) begin
    if (hreset) begin
      state_q      <= ST_IDLE;
      penable_q    <= 1'b0;
      pwrite_q     <= 1'b0;
      pselx_q      <= '0;
      paddr_q      <= '0;
      pwdata_q     <= '0;
      ready_q      <= 1'b1;
      addr_a_q     <= '0;
      addr_b_q     <= '0;
      hwrite_reg_q <= 1'b0;
      wdata_r_q    <= '0;
      wr_acc_q     <= 1'b0;
`ifdef APB_PSLVERR_EN
      hresp_q      <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      penable_q    <= penable_d;
      pwrite_q     <= pwrite_d;
      pselx_q      <= pselx_d;
      paddr_q      <= paddr_d;
      pwdata_q     <= pwdata_d;
      ready_q      <= ready_d;
      addr_a_q     <= addr_a_d;
      addr_b_q     <= addr_b_d;
      hwrite_reg_q <= hwrite_reg_d;
      wdata_r_q    <= wdata_r_d;
      wr_acc_q     <= wr_acc_d;
`ifdef APB_PSLVERR_EN
      hresp_q      <= hresp_d;
`endif
    end
  end

  assign penable     = penable_q;
  assign pwrite      = pwrite_q;
  assign pselx       = pselx_q;
  assign paddr       = paddr_q;
  assign pwdata      = pwdata_q;
  assign hr_readyout = ready_q;
  assign hrdata      = (state_q == ST_RENABLE) ? prdata : '0;

endmodule

// File: tb/tb_apb_controller.sv
// Directed bench for apb_controller: reset, single read/write, pipelined writes,
// write-then-read ordering, undecoded address (and pslverr when APB_PSLVERR_EN).
module tb_apb_controller;

  logic        hclk;
  logic        hreset;
  logic        valid;
  logic [31:0] haddr;
  logic        hwrite;
  logic [31:0] hwdata;
  logic [31:0] prdata;
  logic        penable;
  logic        pwrite;
  logic [2:0]  pselx;
  logic [31:0] paddr;
  logic [31:0] pwdata;
  logic        hr_readyout;
  logic [31:0] hrdata;
`ifdef APB_PSLVERR_EN
  logic        pslverr;
  logic        hresp;
`endif

  int checks = 0;
  int errors = 0;

  apb_controller #(.ADDR_W(32), .DATA_W(32), .NSLV(3)) dut (
    .hclk        (hclk),
    .hreset      (hreset),
    .valid       (valid),
    .haddr       (haddr),
    .hwrite      (hwrite),
    .hwdata      (hwdata),
    .prdata      (prdata),
`ifdef APB_PSLVERR_EN
    .pslverr     (pslverr),
`endif
    .penable     (penable),
    .pwrite      (pwrite),
    .pselx       (pselx),
    .paddr       (paddr),
    .pwdata      (pwdata),
    .hr_readyout (hr_readyout),
`ifdef APB_PSLVERR_EN
    .hresp       (hresp),
`endif
    .hrdata      (hrdata)
  );

  initial hclk = 1'b0;
  always #5 hclk = ~hclk;

  task automatic tick();
    @(posedge hclk);
    #1;
  endtask

  task automatic test_reset();
    hreset = 1'b1; valid = 1'b0; haddr = '0; hwrite = 1'b0; hwdata = '0; prdata = '0;
`ifdef APB_PSLVERR_EN
    pslverr = 1'b0;
`endif
    tick(); tick();
    checks++; if (penable !== 1'b0) begin errors++; $display("FAIL rst_penable got %b exp 0", penable); end
    checks++; if (pselx !== 3'b000) begin errors++; $display("FAIL rst_pselx got %b exp 000", pselx); end
    checks++; if (hr_readyout !== 1'b1) begin errors++; $display("FAIL rst_ready got %b exp 1", hr_readyout); end
    checks++; if (paddr !== 32'h0 || pwdata !== 32'h0 || pwrite !== 1'b0) begin errors++; $display("FAIL rst_bus got paddr %h pwdata %h pwrite %b exp 0", paddr, pwdata, pwrite); end
    hreset = 1'b0;
    // Start a write, then reset in its SETUP phase.
    valid = 1'b1; hwrite = 1'b1; haddr = 32'h8400_0020;
    tick();
    valid = 1'b0; hwdata = 32'h0000_0077;
    tick();
    checks++; if (pselx !== 3'b010) begin errors++; $display("FAIL midwr_pselx got %b exp 010", pselx); end
    hreset = 1'b1;
    tick(); tick();
    checks++; if (pselx !== 3'b000 || penable !== 1'b0 || pwrite !== 1'b0) begin errors++; $display("FAIL midrst_ctrl got pselx %b penable %b pwrite %b exp 000 0 0", pselx, penable, pwrite); end
    checks++; if (paddr !== 32'h0 || pwdata !== 32'h0 || hr_readyout !== 1'b1) begin errors++; $display("FAIL midrst_bus got paddr %h pwdata %h ready %b exp 0 0 1", paddr, pwdata, hr_readyout); end
    hreset = 1'b0;
    tick();
    checks++; if (pselx !== 3'b000 || penable !== 1'b0 || hr_readyout !== 1'b1) begin errors++; $display("FAIL postrst_idle got pselx %b penable %b ready %b exp 000 0 1", pselx, penable, hr_readyout); end
  endtask

  task automatic test_read();
    valid = 1'b1; hwrite = 1'b0; haddr = 32'h8000_0010; prdata = 32'hDEAD_BEEF;
    tick();
    valid = 1'b0;
    checks++; if (pselx !== 3'b001 || paddr !== 32'h8000_0010) begin errors++; $display("FAIL rd_setup got pselx %b paddr %h exp 001 80000010", pselx, paddr); end
    checks++; if (penable !== 1'b0 || pwrite !== 1'b0 || hr_readyout !== 1'b0) begin errors++; $display("FAIL rd_setup_ctrl got pen %b pwr %b rdy %b exp 0 0 0", penable, pwrite, hr_readyout); end
    checks++; if (hrdata !== 32'h0) begin errors++; $display("FAIL rd_setup_hrdata got %h exp 0", hrdata); end
    tick();
    checks++; if (penable !== 1'b1 || pselx !== 3'b001 || hr_readyout !== 1'b1) begin errors++; $display("FAIL rd_enable got pen %b psel %b rdy %b exp 1 001 1", penable, pselx, hr_readyout); end
    checks++; if (hrdata !== 32'hDEAD_BEEF) begin errors++; $display("FAIL rd_hrdata got %h exp deadbeef", hrdata); end
    tick();
    checks++; if (pselx !== 3'b000 || penable !== 1'b0 || hrdata !== 32'h0) begin errors++; $display("FAIL rd_idle got psel %b pen %b hrdata %h exp 000 0 0", pselx, penable, hrdata); end
  endtask

  task automatic test_write();
    valid = 1'b1; hwrite = 1'b1; haddr = 32'h8400_0004;
    tick();
    checks++; if (pselx !== 3'b000 || hr_readyout !== 1'b1) begin errors++; $display("FAIL wr_wwait got psel %b rdy %b exp 000 1", pselx, hr_readyout); end
    valid = 1'b0; hwdata = 32'h1234_5678;
    tick();
    checks++; if (pselx !== 3'b010 || pwrite !== 1'b1 || paddr !== 32'h8400_0004) begin errors++; $display("FAIL wr_setup got psel %b pwr %b paddr %h exp 010 1 84000004", pselx, pwrite, paddr); end
    checks++; if (pwdata !== 32'h1234_5678 || penable !== 1'b0 || hr_readyout !== 1'b0) begin errors++; $display("FAIL wr_setup_data got pwdata %h pen %b rdy %b exp 12345678 0 0", pwdata, penable, hr_readyout); end
    // Offered while not ready: must be ignored.
    valid = 1'b1; hwrite = 1'b1; haddr = 32'h8800_00F0; hwdata = 32'hFFFF_FFFF;
    tick();
    valid = 1'b0;
    checks++; if (penable !== 1'b1 || pselx !== 3'b010 || pwdata !== 32'h1234_5678 || hr_readyout !== 1'b1) begin errors++; $display("FAIL wr_enable got pen %b psel %b pwdata %h rdy %b exp 1 010 12345678 1", penable, pselx, pwdata, hr_readyout); end
    tick();
    checks++; if (pselx !== 3'b000 || penable !== 1'b0 || hr_readyout !== 1'b1) begin errors++; $display("FAIL wr_ignored_valid got psel %b pen %b rdy %b exp 000 0 1", pselx, penable, hr_readyout); end
  endtask

  task automatic test_back_to_back();
    valid = 1'b1; hwrite = 1'b1; haddr = 32'h8800_0000;
    tick();
    haddr = 32'h8800_0004; hwdata = 32'h0000_000A;
    tick();
    valid = 1'b0; hwdata = 32'h0000_000B;
    checks++; if (paddr !== 32'h8800_0000 || pwdata !== 32'hA || pselx !== 3'b100 || penable !== 1'b0 || hr_readyout !== 1'b0) begin errors++; $display("FAIL b2b_setup1 got paddr %h pwdata %h psel %b pen %b rdy %b exp 88000000 a 100 0 0", paddr, pwdata, pselx, penable, hr_readyout); end
    tick();
    hwdata = 32'h0;
    checks++; if (penable !== 1'b1 || paddr !== 32'h8800_0000 || hr_readyout !== 1'b1) begin errors++; $display("FAIL b2b_enable1 got pen %b paddr %h rdy %b exp 1 88000000 1", penable, paddr, hr_readyout); end
    tick();
    checks++; if (paddr !== 32'h8800_0004 || pwdata !== 32'hB || pselx !== 3'b100 || pwrite !== 1'b1 || penable !== 1'b0) begin errors++; $display("FAIL b2b_setup2 got paddr %h pwdata %h psel %b pwr %b pen %b exp 88000004 b 100 1 0", paddr, pwdata, pselx, pwrite, penable); end
    tick();
    checks++; if (penable !== 1'b1 || paddr !== 32'h8800_0004 || hr_readyout !== 1'b1) begin errors++; $display("FAIL b2b_enable2 got pen %b paddr %h rdy %b exp 1 88000004 1", penable, paddr, hr_readyout); end
    tick();
    checks++; if (pselx !== 3'b000 || penable !== 1'b0) begin errors++; $display("FAIL b2b_idle got psel %b pen %b exp 000 0", pselx, penable); end
  endtask

  task automatic test_write_then_read();
    valid = 1'b1; hwrite = 1'b1; haddr = 32'h8400_0008; prdata = 32'hCAFE_0001;
    tick();
    hwrite = 1'b0; haddr = 32'h8000_0000; hwdata = 32'h0000_0055;
    tick();
    valid = 1'b0;
    checks++; if (paddr !== 32'h8400_0008 || pwrite !== 1'b1 || pselx !== 3'b010 || pwdata !== 32'h55) begin errors++; $display("FAIL wr_rd_wsetup got paddr %h pwr %b psel %b pwdata %h exp 84000008 1 010 55", paddr, pwrite, pselx, pwdata); end
    tick();
    checks++; if (penable !== 1'b1 || pwrite !== 1'b1 || paddr !== 32'h8400_0008) begin errors++; $display("FAIL wr_rd_wenable got pen %b pwr %b paddr %h exp 1 1 84000008", penable, pwrite, paddr); end
    tick();
    checks++; if (paddr !== 32'h8000_0000 || pwrite !== 1'b0 || pselx !== 3'b001 || penable !== 1'b0 || hr_readyout !== 1'b0) begin errors++; $display("FAIL wr_rd_rsetup got paddr %h pwr %b psel %b pen %b rdy %b exp 80000000 0 001 0 0", paddr, pwrite, pselx, penable, hr_readyout); end
    tick();
    checks++; if (penable !== 1'b1 || hrdata !== 32'hCAFE_0001) begin errors++; $display("FAIL wr_rd_renable got pen %b hrdata %h exp 1 cafe0001", penable, hrdata); end
    tick();
  endtask

  task automatic test_undecoded();
    valid = 1'b1; hwrite = 1'b0; haddr = 32'h9000_0000; prdata = 32'h0BAD_0BAD;
    tick();
    valid = 1'b0;
    checks++; if (pselx !== 3'b000 || paddr !== 32'h9000_0000 || hr_readyout !== 1'b0) begin errors++; $display("FAIL undec_setup got psel %b paddr %h rdy %b exp 000 90000000 0", pselx, paddr, hr_readyout); end
`ifdef APB_PSLVERR_EN
    pslverr = 1'b1;
`endif
    tick();
    checks++; if (penable !== 1'b1 || pselx !== 3'b000 || hr_readyout !== 1'b1) begin errors++; $display("FAIL undec_enable got pen %b psel %b rdy %b exp 1 000 1", penable, pselx, hr_readyout); end
`ifdef APB_PSLVERR_EN
    checks++; if (hresp !== 1'b0) begin errors++; $display("FAIL undec_hresp_pre got %b exp 0", hresp); end
`endif
    tick();
`ifdef APB_PSLVERR_EN
    pslverr = 1'b0;
    checks++; if (hresp !== 1'b1) begin errors++; $display("FAIL undec_hresp got %b exp 1", hresp); end
`endif
    checks++; if (penable !== 1'b0 || hr_readyout !== 1'b1) begin errors++; $display("FAIL undec_done got pen %b rdy %b exp 0 1", penable, hr_readyout); end
    tick();
`ifdef APB_PSLVERR_EN
    checks++; if (hresp !== 1'b0) begin errors++; $display("FAIL undec_hresp_clr got %b exp 0", hresp); end
`endif
  endtask

  initial begin
    test_reset();
    test_read();
    test_write();
    test_back_to_back();
    test_write_then_read();
    test_undecoded();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/apb_controller.md
Name: apb_controller

Overview:
- Bridge-side APB master FSM; sits directly upstream of the APB slave interface and drives its penable/pwrite/pselx/paddr/pwdata.
- Consumes qualified AHB address-phase transfers (valid, haddr, hwrite) plus the following data phase (hwdata).
- Sequences APB SETUP/ENABLE phases, including back-to-back write pipelining.
- Returns hr_readyout and hrdata to the AHB slave side.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width.
- NSLV, 3, number of one-hot APB selects.

Ports:
- hclk  in  1  bridge clock.
- hreset  in  1  synchronous, active-high reset.
- valid  in  1  qualified AHB transfer in address phase.
- haddr  in  ADDR_W  address-phase address.
- hwrite  in  1  address-phase direction (1 = write).
- hwdata  in  DATA_W  data-phase write data, one cycle after its address.
- prdata  in  DATA_W  read data from the APB slave.
- penable  out  1  APB enable.
- pwrite  out  1  APB direction.
- pselx  out  NSLV  one-hot slave select.
- paddr  out  ADDR_W  APB address.
- pwdata  out  DATA_W  APB write data.
- hr_readyout  out  1  AHB ready back to master.
- hrdata  out  DATA_W  read data to AHB.

Behaviour:
- Reset (sync, hreset=1 at posedge hclk): state ST_IDLE; penable=0, pwrite=0, pselx=0, paddr=0, pwdata=0, hr_readyout=1. Reset mid-transfer abandons the transfer with no completion.
- APB outputs and hr_readyout are registered, loaded from next_state, so each value is valid during the state it belongs to.
- hrdata = prdata when state is ST_RENABLE, else 0 (combinational).
- Capture regs:
  - addr_a/hwrite_reg load on every cycle with valid=1 and hr_readyout=1.
  - addr_b holds the second pending write address in the pipelined path.
  - wdata_r loads hwdata the cycle after a write address is accepted.
- Decode: haddr[31:26] 6'b100000 gives pselx 001; 6'b100001 gives 010; 6'b100010 gives 100; anything else gives 000, and the transfer still completes with no select.
- States and transitions:
  - ST_IDLE: valid&~hwrite → ST_READ; valid&hwrite → ST_WWAIT; else ST_IDLE.
  - ST_WWAIT: valid → ST_WRITEP; else ST_WRITE.
  - ST_READ: → ST_RENABLE.
  - ST_WRITE: valid → ST_WENABLEP; else ST_WENABLE.
  - ST_WRITEP: → ST_WENABLEP.
  - ST_RENABLE, ST_WENABLE: same transitions as ST_IDLE.
  - ST_WENABLEP: ~hwrite_reg → ST_READ; valid&hwrite_reg → ST_WRITEP; ~valid&hwrite_reg → ST_WRITE.
- Outputs per state:
  - ST_IDLE and ST_WWAIT: pselx=0, penable=0, ready=1.
  - ST_READ: pselx=dec(addr), pwrite=0, penable=0, ready=0.
  - ST_RENABLE: pselx held, penable=1, ready=1.
  - ST_WRITE and ST_WRITEP: pselx=dec(write addr), pwrite=1, paddr=write addr, pwdata=wdata_r, penable=0, ready=0.
  - ST_WENABLE and ST_WENABLEP: penable=1, other outputs held, ready=1.
- Latency:
  - Read: 2 APB cycles, 3 hclk from acceptance to the hrdata sample.
  - Single write: WWAIT+SETUP+ENABLE, 3 cycles.
- Boundaries:
  - valid with hr_readyout=0 is ignored.
  - An SETUP phase is always followed by ENABLE; penable is never 1 without pselx≠0, except for undecoded addresses where pselx=0.
  - A read following a write is issued only after the write's ENABLE completes.

Optional Feature:
- Macro APB_PSLVERR_EN.
- Defined: adds input pslverr (1) and output hresp (1). pslverr sampled high in ST_RENABLE/ST_WENABLE/ST_WENABLEP drives hresp=1 for the next cycle and forces the next state to ST_IDLE, discarding any pipelined write.
- Undefined: neither port exists; behaviour as above.

Decomposition:
- Package apb_bridge_pkg: state enum (8 states), decode base constants SLV0_BASE/SLV1_BASE/SLV2_BASE, ADDR_W/DATA_W defaults.
- Sub-module apb_addr_decode: haddr → one-hot pselx, purely combinational.

Test Plan:
- Reset held 2 cycles mid-write → all outputs 0, hr_readyout=1, state ST_IDLE next cycle.
- Single read: valid=1, hwrite=0, haddr=0x8000_0010, prdata=0xDEAD_BEEF → pselx=001, paddr=0x8000_0010, penable=1 on 3rd cycle, hrdata=0xDEAD_BEEF.
- Single write: haddr=0x8400_0004, hwdata=0x1234_5678 → WWAIT, WRITE, WENABLE; pselx=010, pwrite=1, pwdata=0x1234_5678.
- Back-to-back writes to 0x8800_0000 then 0x8800_0004 with data 0xA, 0xB → WWAIT, WRITEP, WENABLEP, WRITE, WENABLE; two APB writes in order with pselx=100.
- Write then read at 0x8000_0000 → read SETUP starts only after the write ENABLE; hr_readyout low during SETUP.
- Undecoded address 0x9000_0000 read → pselx=000, transfer completes, hr_readyout returns to 1. With APB_PSLVERR_EN, pslverr=1 in ENABLE → hresp=1 for one cycle.
